// File: rtl/nco_fdisc_pkg.sv
// Shared constants and helpers for the NCO frequency discriminator.
//   fdisc_w()  : internal CORDIC x/y width for a given sample width
//   atan_lut() : arctangent table, round(atan(2^-i) * 2^apr / (2*pi))
//   K_GAIN     : CORDIC vectoring gain (not removed in hardware)
package nco_fdisc_pkg;

    localparam int unsigned MPR_DEF = 17;
    localparam int unsigned APR_DEF = 32;
    localparam int unsigned NIT_DEF = 16;
    localparam int unsigned W_DEF   = MPR_DEF + 2;

    localparam real K_GAIN = 1.6467602581210654;

    // Two guard bits: one for negating -2^(mpr-1), one for the K growth.
    function automatic int unsigned fdisc_w(input int unsigned mpr);
        return mpr + 2;
    endfunction

    // Reference table at 32-bit phase, rescaled (with rounding) to apr bits.
    function automatic logic [63:0] atan_lut(input int unsigned i, input int unsigned apr);
        logic [31:0] t;
        int unsigned sh;
        case (i)
            0:  t = 32'h2000_0000;
            1:  t = 32'h12E4_051E;
            2:  t = 32'h09FB_385B;
            3:  t = 32'h0511_11D4;
            4:  t = 32'h028B_0D43;
            5:  t = 32'h0145_D7E1;
            6:  t = 32'h00A2_F61E;
            7:  t = 32'h0051_7C55;
            8:  t = 32'h0028_BE53;
            9:  t = 32'h0014_5F2F;
            10: t = 32'h000A_2F98;
            11: t = 32'h0005_17CC;
            12: t = 32'h0002_8BE6;
            13: t = 32'h0001_45F3;
            14: t = 32'h0000_A2FA;
            15: t = 32'h0000_517D;
            16: t = 32'h0000_28BE;
            17: t = 32'h0000_145F;
            18: t = 32'h0000_0A30;
            19: t = 32'h0000_0518;
            20: t = 32'h0000_028C;
            21: t = 32'h0000_0146;
            22: t = 32'h0000_00A3;
            23: t = 32'h0000_0051;
            24: t = 32'h0000_0029;
            25: t = 32'h0000_0014;
            26: t = 32'h0000_000A;
            27: t = 32'h0000_0005;
            28: t = 32'h0000_0003;
            29: t = 32'h0000_0001;
            30: t = 32'h0000_0001;
            default: t = 32'h0000_0000;
        endcase
        if (apr >= 32) begin
            return 64'(t) << (apr - 32);
        end
        sh = 32 - apr;
        return (64'(t) + (64'(1) << (sh - 1))) >> sh;
    endfunction

endpackage

// File: rtl/nco_fdisc_cordic_stage.sv
// One registered CORDIC vectoring micro-rotation (drives y toward zero).
// Parameters: w (x/y width), apr (phase width), i (stage index / shift).
// Ports: clk, reset (sync, active-high), clken; valid/zero flags, x/y/z in;
//        registered valid/zero flags, x/y/z out.
module nco_fdisc_cordic_stage
    import nco_fdisc_pkg::*;
#(
    parameter int unsigned w   = 19,
    parameter int unsigned apr = 32,
    parameter int unsigned i   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  valid_i,
    input  logic                  zero_i,
    input  logic signed [w-1:0]   x_i,
    input  logic signed [w-1:0]   y_i,
    input  logic [apr-1:0]        z_i,
    output logic                  valid_o,
    output logic                  zero_o,
    output logic signed [w-1:0]   x_o,
    output logic signed [w-1:0]   y_o,
    output logic [apr-1:0]        z_o
);

    localparam logic [apr-1:0] ATAN = apr'(atan_lut(i, apr));

    logic                valid_q, valid_d;
    logic                zero_q, zero_d;
    logic signed [w-1:0] x_q, x_d;
    logic signed [w-1:0] y_q, y_d;
    logic [apr-1:0]      z_q, z_d;

    // Micro-rotation; both updates use the stage-input x and y.
    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        if (clken) begin
            valid_d = valid_i;
            zero_d  = zero_i;
            if (!y_i[w-1]) begin
                x_d = x_i + (y_i >>> i);
                y_d = y_i - (x_i >>> i);
                z_d = z_i + ATAN;
            end else begin
                x_d = x_i - (y_i >>> i);
                y_d = y_i + (x_i >>> i);
                z_d = z_i - ATAN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign valid_o = valid_q;
    assign zero_o  = zero_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;

endmodule

// File: rtl/nco_fdisc_st.sv
// NCO frequency discriminator: recovers phase and magnitude of I/Q samples
// with a pipelined CORDIC and reports the wrapped phase step between
// successive valid samples (inverse of the NCO phase increment).
// Optional block averaging of the phase step: define NCO_FDISC_AVG_EN.
// Ports: clk, reset (sync, active-high), clken (global enable),
//        in_valid, fsin_i/fcos_i (signed Q/I samples),
//        phase_o (angle), phase_inc_o (phase step), mag_o (K-scaled
//        magnitude), out_valid (one pulse per result).
module nco_fdisc_st
    import nco_fdisc_pkg::*;
#(
    parameter int unsigned mpr = 17,
    parameter int unsigned apr = 32,
    parameter int unsigned nit = 16
`ifdef NCO_FDISC_AVG_EN
    ,
    parameter int unsigned avl = 4
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  in_valid,
    input  logic signed [mpr-1:0] fsin_i,
    input  logic signed [mpr-1:0] fcos_i,
    output logic [apr-1:0]        phase_o,
    output logic [apr-1:0]        phase_inc_o,
    output logic [mpr:0]          mag_o,
    output logic                  out_valid
);

    localparam int unsigned w = fdisc_w(mpr);

    // Pipeline taps: index 0 is the pre-rotation register, nit the last stage.
    logic                v_s  [0:nit];
    logic                zf_s [0:nit];
    logic signed [w-1:0] x_s  [0:nit];
    logic signed [w-1:0] y_s  [0:nit];
    logic [apr-1:0]      z_s  [0:nit];

    // ---------------- pre-rotation into the right half-plane ----------------
    logic                pv_q, pv_d;
    logic                pz_q, pz_d;
    logic signed [w-1:0] px_q, px_d;
    logic signed [w-1:0] py_q, py_d;
    logic [apr-1:0]      pa_q, pa_d;

    always_comb begin
        pv_d = pv_q;
        pz_d = pz_q;
        px_d = px_q;
        py_d = py_q;
        pa_d = pa_q;
        if (clken) begin
            pv_d = in_valid;
            pz_d = (fsin_i == '0) && (fcos_i == '0);
            if (fcos_i[mpr-1]) begin
                px_d = -w'(fcos_i);
                py_d = -w'(fsin_i);
                pa_d = {1'b1, {(apr-1){1'b0}}};
            end else begin
                px_d = w'(fcos_i);
                py_d = w'(fsin_i);
                pa_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q <= 1'b0;
            pz_q <= 1'b0;
            px_q <= '0;
            py_q <= '0;
            pa_q <= '0;
        end else begin
            pv_q <= pv_d;
            pz_q <= pz_d;
            px_q <= px_d;
            py_q <= py_d;
            pa_q <= pa_d;
        end
    end

    assign v_s[0]  = pv_q;
    assign zf_s[0] = pz_q;
    assign x_s[0]  = px_q;
    assign y_s[0]  = py_q;
    assign z_s[0]  = pa_q;

    // ---------------- CORDIC micro-rotations ----------------
    for (genvar k = 0; k < nit; k++) begin : g_stage
        nco_fdisc_cordic_stage #(
            .w   (w),
            .apr (apr),
            .i   (k)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clken   (clken),
            .valid_i (v_s[k]),
            .zero_i  (zf_s[k]),
            .x_i     (x_s[k]),
            .y_i     (y_s[k]),
            .z_i     (z_s[k]),
            .valid_o (v_s[k+1]),
            .zero_o  (zf_s[k+1]),
            .x_o     (x_s[k+1]),
            .y_o     (y_s[k+1]),
            .z_o     (z_s[k+1])
        );
    end

    // Residual y and the x sign bit (x is never negative here) are not needed.
    logic unused_bits;
    assign unused_bits = ^{y_s[nit], x_s[nit][w-1]};

    // ---------------- phase difference ----------------
    logic           primed_q, primed_d;
    logic [apr-1:0] zprev_q, zprev_d;
    logic           res_valid_q, res_valid_d;
    logic [apr-1:0] res_phase_q, res_phase_d;
    logic [apr-1:0] res_inc_q, res_inc_d;
    logic [mpr:0]   res_mag_q, res_mag_d;

    // First result after reset only primes z_prev; zero samples hold z_prev.
    always_comb begin
        primed_d    = primed_q;
        zprev_d     = zprev_q;
        res_valid_d = res_valid_q;
        res_phase_d = res_phase_q;
        res_inc_d   = res_inc_q;
        res_mag_d   = res_mag_q;
        if (clken) begin
            res_valid_d = 1'b0;
            if (v_s[nit]) begin
                if (!primed_q) begin
                    primed_d = 1'b1;
                    if (zf_s[nit]) begin
                        res_phase_d = zprev_q;
                    end else begin
                        res_phase_d = z_s[nit];
                        zprev_d     = z_s[nit];
                    end
                end else begin
                    res_valid_d = 1'b1;
                    if (zf_s[nit]) begin
                        res_phase_d = zprev_q;
                        res_inc_d   = '0;
                        res_mag_d   = '0;
                    end else begin
                        res_phase_d = z_s[nit];
                        res_inc_d   = z_s[nit] - zprev_q;
                        res_mag_d   = x_s[nit][mpr:0];
                        zprev_d     = z_s[nit];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            primed_q    <= 1'b0;
            zprev_q     <= '0;
            res_valid_q <= 1'b0;
            res_phase_q <= '0;
            res_inc_q   <= '0;
            res_mag_q   <= '0;
        end else begin
            primed_q    <= primed_d;
            zprev_q     <= zprev_d;
            res_valid_q <= res_valid_d;
            res_phase_q <= res_phase_d;
            res_inc_q   <= res_inc_d;
            res_mag_q   <= res_mag_d;
        end
    end

`ifdef NCO_FDISC_AVG_EN
    // ---------------- block averaging of the phase step ----------------
    localparam int unsigned accw = apr + avl;

    logic [accw-1:0] acc_q, acc_d;
    logic [avl-1:0]  cnt_q, cnt_d;
    logic [accw-1:0] sum;
    logic            ov_q, ov_d;
    logic [apr-1:0]  oph_q, oph_d;
    logic [apr-1:0]  oinc_q, oinc_d;
    logic [mpr:0]    omag_q, omag_d;

    // Sign-extended running sum; the arithmetic >>avl is the top apr bits.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ov_d   = ov_q;
        oph_d  = oph_q;
        oinc_d = oinc_q;
        omag_d = omag_q;
        sum    = acc_q + {{avl{res_inc_q[apr-1]}}, res_inc_q};
        if (clken) begin
            ov_d = 1'b0;
            if (res_valid_q) begin
                if (cnt_q == {avl{1'b1}}) begin
                    ov_d   = 1'b1;
                    oinc_d = sum[accw-1:avl];
                    oph_d  = res_phase_q;
                    omag_d = res_mag_q;
                    acc_d  = '0;
                    cnt_d  = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            ov_q   <= 1'b0;
            oph_q  <= '0;
            oinc_q <= '0;
            omag_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            oph_q  <= oph_d;
            oinc_q <= oinc_d;
            omag_q <= omag_d;
        end
    end

    assign out_valid   = ov_q;
    assign phase_o     = oph_q;
    assign phase_inc_o = oinc_q;
    assign mag_o       = omag_q;
`else
    assign out_valid   = res_valid_q;
    assign phase_o     = res_phase_q;
    assign phase_inc_o = res_inc_q;
    assign mag_o       = res_mag_q;
`endif

endmodule

// File: tb/tb_nco_fdisc_st.sv
// Scoreboard bench for nco_fdisc_st: stimulus pushes expected results,
// a monitor pops and compares on every out_valid pulse.
module tb_nco_fdisc_st;
    import nco_fdisc_pkg::*;

    localparam int unsigned MPR = 17;
    localparam int unsigned APR = 32;
    localparam int unsigned NIT = 16;
`ifdef NCO_FDISC_AVG_EN
    localparam int LAT = NIT + 3;
`else
    localparam int LAT = NIT + 2;
`endif
    localparam int  PH_TOL  = 1 << 18;
    localparam int  MAG_TOL = 64;
    localparam real M_PI    = 3.14159265358979;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  clken = 1'b1;
    logic                  in_valid = 1'b0;
    logic signed [MPR-1:0] fsin_i = '0;
    logic signed [MPR-1:0] fcos_i = '0;
    logic [APR-1:0]        phase_o;
    logic [APR-1:0]        phase_inc_o;
    logic [MPR:0]          mag_o;
    logic                  out_valid;

    nco_fdisc_st dut (
        .clk         (clk),
        .reset       (reset),
        .clken       (clken),
        .in_valid    (in_valid),
        .fsin_i      (fsin_i),
        .fcos_i      (fcos_i),
        .phase_o     (phase_o),
        .phase_inc_o (phase_inc_o),
        .mag_o       (mag_o),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ph;
        logic [31:0] inc;
        int          mag;
        int          ptol;
        int          itol;
        int          mtol;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ce_cnt = 0;
    logic edge_en = 1'b0;
    bit   gap_mode = 1'b0;

    // Reference model state
    bit          m_primed = 1'b0;
    logic [31:0] m_prev = '0;
    longint      m_acc = 0;
    int          m_cnt = 0;

    // Count clken edges; remember whether the last edge was enabled.
    always @(posedge clk) begin
        ce_cnt  <= ce_cnt + (clken ? 1 : 0);
        edge_en <= clken;
    end

    task automatic chk_wrap(input string name, input logic [31:0] got, input logic [31:0] want, input int tol);
        logic [31:0] d;
        int e;
        d = got - want;
        e = int'(signed'(d));
        if (e < 0) e = -e;
        checks++;
        if (e > tol) begin
            errors++;
            $display("FAIL %s got %h want %h (tol %0d)", name, got, want, tol);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want, input int tol);
        int e;
        e = got - want;
        if (e < 0) e = -e;
        checks++;
        if (e > tol) begin
            errors++;
            $display("FAIL %s got %0d want %0d (tol %0d)", name, got, want, tol);
        end
    endtask

    // Monitor: consume a result only right after an enabled edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && edge_en && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid got 1 want 0 phase_inc %h", phase_inc_o);
            end else begin
                e = exp_q.pop_front();
                chk_wrap("phase_inc", phase_inc_o, e.inc, e.itol);
                chk_wrap("phase", phase_o, e.ph, e.ptol);
                chk_int("mag", int'(mag_o), e.mag, e.mtol);
                chk_int("latency", ce_cnt - e.tag, LAT, 0);
            end
        end
    end

    task automatic push_exp(input logic [31:0] ph, input logic [31:0] inc, input int mag,
                            input int itol, input int mtol, input int tag);
`ifdef NCO_FDISC_AVG_EN
        m_acc = m_acc + longint'(int'(signed'(inc)));
        m_cnt++;
        if (m_cnt == 16) begin
            exp_q.push_back('{ph, 32'(m_acc >>> 4), mag, PH_TOL, PH_TOL, mtol, tag});
            m_acc = 0;
            m_cnt = 0;
        end
`else
        exp_q.push_back('{ph, inc, mag, PH_TOL, itol, mtol, tag});
`endif
    endtask

    task automatic model(input logic [31:0] ph, input real amp, input bit is_zero, input int tag);
        if (!m_primed) begin
            m_primed = 1'b1;
            if (!is_zero) m_prev = ph;
        end else if (is_zero) begin
            push_exp(m_prev, 32'h0, 0, 0, 0, tag);
        end else begin
            push_exp(ph, ph - m_prev, int'(amp * K_GAIN), PH_TOL, MAG_TOL, tag);
            m_prev = ph;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        clken    = 1'b1;
        in_valid = 1'b0;
        fsin_i   = '0;
        fcos_i   = '0;
    endtask

    task automatic send(input logic [31:0] ph, input real amp, input bit is_zero);
        int  s;
        int  c;
        real a;
        a = 2.0 * M_PI * real'(ph) / 4294967296.0;
        if (is_zero) begin
            s = 0;
            c = 0;
        end else begin
            s = int'(amp * $sin(a));
            c = int'(amp * $cos(a));
        end
        if (gap_mode) begin
            while ($urandom_range(0, 2) != 0) begin
                @(posedge clk); #1;
                clken    = 1'($urandom_range(0, 1));
                in_valid = clken ? 1'b0 : 1'($urandom_range(0, 1));
                fsin_i   = MPR'($urandom);
                fcos_i   = MPR'($urandom);
            end
        end
        @(posedge clk); #1;
        clken    = 1'b1;
        in_valid = 1'b1;
        fsin_i   = MPR'(s);
        fcos_i   = MPR'(c);
        model(ph, amp, is_zero, ce_cnt);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            idle();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (LAT + 4) idle();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        clken    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_primed = 1'b0;
        m_prev   = '0;
        m_acc    = 0;
        m_cnt    = 0;
        @(negedge clk);
        chk_int("rst_out_valid", int'(out_valid), 0, 0);
        chk_wrap("rst_phase", phase_o, 32'h0, 0);
        chk_wrap("rst_phase_inc", phase_inc_o, 32'h0, 0);
        chk_int("rst_mag", int'(mag_o), 0, 0);
    endtask

    initial begin
        logic [31:0] ph;
        repeat (3) @(posedge clk);
        do_reset();

        // Rotating phasor, amplitude 60000, step 0x0100_0000
        ph = 32'h0;
        for (int n = 0; n < 20; n++) begin
            send(ph, 60000.0, 1'b0);
            ph = ph + 32'h0100_0000;
        end
        drain();

        // Static vectors on the positive and negative real axis
        for (int n = 0; n < 4; n++) send(32'h0000_0000, 65535.0, 1'b0);
        for (int n = 0; n < 4; n++) send(32'h8000_0000, 65536.0, 1'b0);
        drain();

        // Negative step crossing +/-pi
        ph = 32'h8600_0000;
        for (int n = 0; n < 12; n++) begin
            send(ph, 60000.0, 1'b0);
            ph = ph - 32'h0100_0000;
        end
        drain();

        // Random clken and bubbles, one zero sample mid-run
        gap_mode = 1'b1;
        ph = 32'h1000_0000;
        for (int n = 0; n < 24; n++) begin
            send(ph, 60000.0, n == 12);
            ph = ph + 32'h0100_0000;
        end
        gap_mode = 1'b0;
        drain();

        // Reset with samples in flight, then re-prime
        ph = 32'h0;
        for (int n = 0; n < 3; n++) begin
            send(ph, 60000.0, 1'b0);
            ph = ph + 32'h0100_0000;
        end
        do_reset();
        ph = 32'h2000_0000;
        for (int n = 0; n < 4; n++) begin
            send(ph, 60000.0, 1'b0);
            ph = ph + 32'h0100_0000;
        end
        drain();

`ifdef NCO_FDISC_AVG_EN
        // Block averaging: prime plus 32 results, one zero sample
        do_reset();
        ph = 32'h0;
        for (int n = 0; n < 33; n++) begin
            send(ph, 60000.0, n == 20);
            ph = ph + 32'h0040_0000;
        end
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
